// File: rtl/param_queue_pkg.sv
// param_queue_pkg: shared defaults and the registered status bundle
package param_queue_pkg;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 8;
   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
      logic overflow;
      logic underflow;
   } queue_status_t;
endpackage

// File: rtl/param_queue_if.sv
// param_queue_if: request/response bundle between a producer-consumer and the queue
interface param_queue_if import param_queue_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
);
   logic                     flush_in;
   logic                     clear_err_in;
   logic [DATA_W-1:0]        data_in;
   logic                     enqueue_in;
   logic                     dequeue_in;
   logic [DATA_W-1:0]        data_out;
   logic                     valid_out;
   logic [$clog2(DEPTH):0]   len_out;
   logic                     full_out;
   logic                     empty_out;
   logic                     almost_full_out;
   logic                     almost_empty_out;
   logic                     overflow_out;
   logic                     underflow_out;
   modport slave (
      input  flush_in, clear_err_in, data_in, enqueue_in, dequeue_in,
      output data_out, valid_out, len_out, full_out, empty_out,
             almost_full_out, almost_empty_out, overflow_out, underflow_out
   );
   modport master (
      output flush_in, clear_err_in, data_in, enqueue_in, dequeue_in,
      input  data_out, valid_out, len_out, full_out, empty_out,
             almost_full_out, almost_empty_out, overflow_out, underflow_out
   );
endinterface

// File: rtl/param_queue_mem.sv
// queue_mem: storage array, synchronous write and combinational read
module queue_mem import param_queue_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic                       clk_i,
   input  logic                       we_i,
   input  logic [$clog2(DEPTH)-1:0]   waddr_i,
   input  logic [DATA_W-1:0]          wdata_i,
   input  logic [$clog2(DEPTH)-1:0]   raddr_i,
   output logic [DATA_W-1:0]          rdata_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   // Write port; contents are never reset, the pointers decide what is live
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/param_queue.sv
// param_queue: circular-buffer FIFO with occupancy, threshold flags and sticky errors
module param_queue import param_queue_pkg::*; #(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic          clk_10khz,
   input  logic          reset_n,
   param_queue_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_L = LW'(DEPTH);
   localparam logic [LW-1:0] AF_L   = LW'(AF_LEVEL);
   localparam logic [LW-1:0] AE_L   = LW'(AE_LEVEL);

   logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
   logic [LW-1:0]     len_q, len_d;
   logic [DATA_W-1:0] data_q, data_d, rdata;
   logic              valid_q, valid_d;
   queue_status_t     st_q, st_d;
   logic              deq_ok, enq_ok, we;

   queue_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
      .clk_i   (clk_10khz),
      .we_i    (we),
      .waddr_i (wr_q),
      .wdata_i (bus.data_in),
      .raddr_i (rd_q),
      .rdata_o (rdata)
   );

   // Acceptance, next pointers/length, and flags derived from the next length
   always_comb begin
      deq_ok         = bus.dequeue_in && len_q != '0;
      enq_ok         = bus.enqueue_in && (len_q != FULL_L || deq_ok);
      we             = enq_ok && !bus.flush_in;
      wr_d           = bus.flush_in ? '0 : wr_q + AW'(enq_ok);
      rd_d           = bus.flush_in ? '0 : rd_q + AW'(deq_ok);
      len_d          = bus.flush_in ? '0 : len_q + LW'(enq_ok) - LW'(deq_ok);
      valid_d        = deq_ok && !bus.flush_in;
      data_d         = valid_d ? rdata : data_q;
      st_d.full         = len_d == FULL_L;
      st_d.empty        = len_d == '0;
      st_d.almost_full  = len_d >= AF_L;
      st_d.almost_empty = len_d <= AE_L;
      st_d.overflow  = bus.flush_in ? st_q.overflow :
                       (bus.enqueue_in && !enq_ok) || (st_q.overflow && !bus.clear_err_in);
      st_d.underflow = bus.flush_in ? st_q.underflow :
                       (bus.dequeue_in && !deq_ok) || (st_q.underflow && !bus.clear_err_in);
   end

   // State register with synchronous active-low reset
   always_ff @(posedge clk_10khz) begin
      if (!reset_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         len_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         st_q    <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1,
                      overflow: 1'b0, underflow: 1'b0};
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         len_q   <= len_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         st_q    <= st_d;
      end
   end

   assign bus.data_out         = data_q;
   assign bus.valid_out        = valid_q;
   assign bus.len_out          = len_q;
   assign bus.full_out         = st_q.full;
   assign bus.empty_out        = st_q.empty;
   assign bus.almost_full_out  = st_q.almost_full;
   assign bus.almost_empty_out = st_q.almost_empty;
   assign bus.overflow_out     = st_q.overflow;
   assign bus.underflow_out    = st_q.underflow;
endmodule

// File: doc/param_queue.md
PARAM_QUEUE -- requirements
Module: param_queue

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the entry count; it is a power of two and at least 2.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, giving the almost-full threshold; almost_full_out is 1 when len >= AF_LEVEL.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, giving the almost-empty threshold; almost_empty_out is 1 when len <= AE_LEVEL.
REQ-005 The block SHALL have the following ports, one per line: name, direction, width, meaning.
  clk_10khz  in  1  sole clock; all state changes on its rising edge.
  reset_n  in  1  synchronous, active-low reset.
  flush_in  in  1  discard all contents.
  clear_err_in  in  1  clear the sticky error flags.
  data_in  in  DATA_W  enqueue data.
  enqueue_in  in  1  enqueue request.
  dequeue_in  in  1  dequeue request.
  data_out  out  DATA_W  registered head value from the last accepted dequeue.
  valid_out  out  1  one-cycle pulse marking data_out as new.
  len_out  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
  full_out, empty_out, almost_full_out, almost_empty_out  out  1 each  registered status flags.
  overflow_out, underflow_out  out  1 each  sticky error flags.

Function
REQ-006 Ordering SHALL be strict FIFO, with circular write and read pointers of width $clog2(DEPTH) that wrap from DEPTH-1 to 0.
REQ-007 An enqueue SHALL be accepted when enqueue_in=1 and either len<DEPTH or a dequeue is accepted in the same cycle.
REQ-008 A dequeue SHALL be accepted when dequeue_in=1 and len>0; there is no same-cycle enqueue-to-dequeue bypass.
REQ-009 On an accepted dequeue, data_out SHALL take the head entry at the next edge and valid_out SHALL be 1 for exactly that cycle; otherwise data_out holds and valid_out=0.
REQ-010 len_out SHALL be +1 for an enqueue alone, -1 for a dequeue alone, and unchanged when both are accepted.
REQ-011 When full with both requests asserted, both SHALL be accepted and len SHALL stay at DEPTH.
REQ-012 When empty with both requests asserted, the enqueue SHALL be accepted, the dequeue rejected, underflow_out set, and len SHALL become 1.
REQ-013 A rejected enqueue (full, no dequeue) SHALL leave contents and len unchanged and SHALL set overflow_out.
REQ-014 A rejected dequeue SHALL leave data_out unchanged and SHALL set underflow_out.
REQ-015 overflow_out and underflow_out SHALL stay set until clear_err_in=1 or reset; if an error and clear_err_in occur in the same cycle, the flag SHALL be set.
REQ-016 flush_in=1 SHALL zero both pointers and len; enqueue/dequeue in that cycle SHALL be ignored and no error set; data_out and the error flags hold.
REQ-017 Priority SHALL be: reset_n, then flush_in, then enqueue/dequeue.
REQ-018 The status flags SHALL be derived from next-state len and registered, so they are consistent with len_out in every cycle.

Reset
REQ-019 While reset_n=0 at a clock edge, the block SHALL set pointers=0, len_out=0, data_out=0, valid_out=0, empty_out=1, almost_empty_out=1, full_out=0, almost_full_out=0, overflow_out=0 and underflow_out=0.
REQ-020 Reset asserted mid-operation SHALL discard all contents, and the storage array SHALL need no reset.

Structure
REQ-021 Package param_queue_pkg SHALL hold DEF_DATA_W=8, DEF_DEPTH=8 and typedef queue_status_t, a packed struct of full, empty, almost_full, almost_empty, overflow and underflow.
REQ-022 Storage SHALL be one sub-module, queue_mem, a DEPTH x DATA_W synchronous-write, asynchronous-read array; pointer and flag logic SHALL stay in param_queue.

Verification (defaults: DATA_W=8, DEPTH=8)
REQ-023 Reset then enqueue A5 for one cycle -> len_out=1, empty_out=0, almost_empty_out=1.
REQ-024 Enqueue 01..08 -> len_out=8, full_out=1, almost_full_out=1 from len 6; then enqueue FF -> len_out=8, overflow_out=1, contents unchanged.
REQ-025 Full queue, enqueue 77 and dequeue together -> len_out=8, data_out=01, valid_out pulses once, and 77 later dequeues last.
REQ-026 Empty queue, enqueue 3C and dequeue together -> len_out=1, underflow_out=1, valid_out=0; next dequeue gives data_out=3C.
REQ-027 Enqueue and dequeue 20 values so pointers wrap twice -> output order is identical to input order.
REQ-028 Fill 5 entries, assert flush_in and enqueue_in together -> len_out=0, empty_out=1, error flags unchanged; then pulse clear_err_in -> overflow_out=0 and underflow_out=0.
